// File: rtl/reorder_buffer_mc.sv
// rtl/reorder_buffer_mc.sv - reorder buffer with multi-port writeback and up to two in-order commits per cycle
// Occupancy is head/tail plus a registered count; branches resolve at slot0 and raise a registered flush.
module reorder_buffer_mc #(
    parameter int ID_W        = 4,
    parameter int NUM_WB      = 2,
    parameter int DUAL_COMMIT = 1,
    parameter int REG_W       = 5,
    parameter int TYPE_W      = 2
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic                   flush,
    output logic                   dec_full,
    output logic [ID_W-1:0]        dec_empty_id,
    input  logic                   dec_rdy,
    input  logic                   dec_committable,
    input  logic [31:0]            dec_res,
    input  logic [31:0]            dec_next_addr,
    input  logic [31:0]            dec_jump_addr,
    input  logic [TYPE_W-1:0]      dec_type,
    input  logic [REG_W-1:0]       dec_dest,
    input  logic                   dec_predict,
    input  logic [NUM_WB-1:0]      wb_valid,
    input  logic [NUM_WB*ID_W-1:0] wb_rob_id,
    input  logic [NUM_WB*32-1:0]   wb_data,
    input  logic [NUM_WB-1:0]      wb_set_jump,
    input  logic [ID_W-1:0]        rd_id_j,
    input  logic [ID_W-1:0]        rd_id_k,
    output logic                   rd_ready_j,
    output logic                   rd_ready_k,
    output logic [31:0]            rd_data_j,
    output logic [31:0]            rd_data_k,
    output logic [REG_W-1:0]       commit0_reg,
    output logic [REG_W-1:0]       commit1_reg,
    output logic [31:0]            commit0_data,
    output logic [31:0]            commit1_data,
    output logic [ID_W-1:0]        commit0_id,
    output logic [1:0]             commit_cnt,
    output logic                   lsb_empty,
    output logic [ID_W-1:0]        lsb_head_id,
    output logic                   br_en,
    output logic [31:0]            br_next_pc,
    output logic                   br_taken,
    output logic                   flush_out,
    output logic [31:0]            correct_pc
);
    localparam int DEPTH = 1 << ID_W;
    localparam logic [ID_W:0] FULL_CNT = (ID_W + 1)'(DEPTH);
    localparam logic [TYPE_W-1:0] REG_ONLY = TYPE_W'(1);

    logic [ID_W-1:0]   head_q, head_d, tail_q, tail_d, head1;
    logic [ID_W:0]     count_q, count_d;
    logic [DEPTH-1:0]  committable_q, committable_d;
    logic [DEPTH-1:0]  predict_q;
    logic [31:0]       res_q       [DEPTH];
    logic [31:0]       next_addr_q [DEPTH];
    logic [31:0]       jump_addr_q [DEPTH];
    logic [TYPE_W-1:0] type_q      [DEPTH];
    logic [REG_W-1:0]  dest_q      [DEPTH];
    logic              flush_out_q;
    logic [31:0]       correct_pc_q;

    logic              slot0, slot1, mispredict, clear;
    logic [ID_W-1:0]   rd_id  [2];
    logic              rd_rdy [2];
    logic [31:0]       rd_dat [2];

    assign head1 = head_q + ID_W'(1);
    assign clear = rdy_in && (flush || flush_out_q);

    // Nothing retires while the mispredict pulse is out: those entries are wrong-path.
    // A store at head retires alone, so the second slot only pairs two plain register writes.
    always_comb begin
        slot0 = (count_q != '0) && committable_q[head_q] && !flush_out_q;
        slot1 = (DUAL_COMMIT != 0) && slot0 && (count_q > (ID_W + 1)'(1)) &&
                committable_q[head1] && (type_q[head_q] == REG_ONLY) &&
                (type_q[head1] == REG_ONLY);
        mispredict = slot0 && type_q[head_q][1] && (predict_q[head_q] != res_q[head_q][0]);
    end

    assign commit_cnt   = {1'b0, slot0} + {1'b0, slot1};
    assign commit0_id   = head_q;
    assign commit0_reg  = (slot0 && type_q[head_q][0]) ? dest_q[head_q] : '0;
    assign commit1_reg  = slot1 ? dest_q[head1] : '0;
    assign commit0_data = res_q[head_q];
    assign commit1_data = res_q[head1];
    assign br_en        = slot0 && type_q[head_q][1];
    assign br_taken     = res_q[head_q][0];
    assign br_next_pc   = next_addr_q[head_q];
    assign dec_full     = (count_q == FULL_CNT);
    assign lsb_empty    = (count_q == '0);
    assign dec_empty_id = tail_q;
    assign lsb_head_id  = head_q;
    assign flush_out    = flush_out_q;
    assign correct_pc   = correct_pc_q;

    always_comb begin
        head_d  = head_q + ID_W'(commit_cnt);
        tail_d  = tail_q + ID_W'(dec_rdy);
        count_d = count_q + (ID_W + 1)'(dec_rdy) - (ID_W + 1)'(commit_cnt);
        committable_d = committable_q;
        if (dec_rdy) begin
            committable_d[tail_q] = dec_committable;
        end
        for (int i = 0; i < NUM_WB; i++) begin
            if (wb_valid[i]) begin
                committable_d[wb_rob_id[i*ID_W +: ID_W]] = 1'b1;
            end
        end
    end

    // Operand bypass: a committable allocation beats writeback, higher port beats lower.
    assign rd_id[0] = rd_id_j;
    assign rd_id[1] = rd_id_k;
    always_comb begin
        for (int r = 0; r < 2; r++) begin
            rd_rdy[r] = committable_q[rd_id[r]];
            rd_dat[r] = res_q[rd_id[r]];
            for (int i = 0; i < NUM_WB; i++) begin
                if (wb_valid[i] && !wb_set_jump[i] && (wb_rob_id[i*ID_W +: ID_W] == rd_id[r])) begin
                    rd_rdy[r] = 1'b1;
                    rd_dat[r] = wb_data[i*32 +: 32];
                end
            end
            if (dec_rdy && dec_committable && (tail_q == rd_id[r])) begin
                rd_rdy[r] = 1'b1;
                rd_dat[r] = dec_res;
            end
        end
    end

    assign rd_ready_j = rd_rdy[0];
    assign rd_ready_k = rd_rdy[1];
    assign rd_data_j  = rd_dat[0];
    assign rd_data_k  = rd_dat[1];

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            committable_q <= '0;
            flush_out_q   <= 1'b0;
            correct_pc_q  <= '0;
        end else if (rdy_in) begin
            if (clear) begin
                head_q        <= '0;
                tail_q        <= '0;
                count_q       <= '0;
                committable_q <= '0;
                flush_out_q   <= 1'b0;
                correct_pc_q  <= '0;
            end else begin
                head_q        <= head_d;
                tail_q        <= tail_d;
                count_q       <= count_d;
                committable_q <= committable_d;
                flush_out_q   <= mispredict;
                if (mispredict) begin
                    correct_pc_q <= predict_q[head_q] ? next_addr_q[head_q] : jump_addr_q[head_q];
                end
            end
        end
    end

    // Payload needs no reset: committable and count gate every use of it.
    always_ff @(posedge clk_in) begin
        if (rst_in && rdy_in && !clear) begin
            if (dec_rdy) begin
                res_q[tail_q]       <= dec_res;
                next_addr_q[tail_q] <= dec_next_addr;
                jump_addr_q[tail_q] <= dec_jump_addr;
                type_q[tail_q]      <= dec_type;
                dest_q[tail_q]      <= dec_dest;
                predict_q[tail_q]   <= dec_predict;
            end
            for (int i = 0; i < NUM_WB; i++) begin
                if (wb_valid[i]) begin
                    if (wb_set_jump[i]) begin
                        jump_addr_q[wb_rob_id[i*ID_W +: ID_W]] <= wb_data[i*32 +: 32];
                    end else begin
                        res_q[wb_rob_id[i*ID_W +: ID_W]] <= wb_data[i*32 +: 32];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_reorder_buffer_mc.sv
// tb/tb_reorder_buffer_mc.sv - vector table, directed corners and queue-model random check of reorder_buffer_mc
module tb_reorder_buffer_mc;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush, dec_rdy, dec_committable, dec_predict;
    logic [31:0] dec_res, dec_next_addr, dec_jump_addr;
    logic [1:0]  dec_type;
    logic [4:0]  dec_dest;
    logic [1:0]  wb_valid, wb_set_jump;
    logic [7:0]  wb_rob_id;
    logic [63:0] wb_data;
    logic [3:0]  rd_id_j, rd_id_k;

    logic        dec_full, rd_ready_j, rd_ready_k, lsb_empty, br_en, br_taken, flush_out;
    logic [3:0]  dec_empty_id, commit0_id, lsb_head_id;
    logic [31:0] rd_data_j, rd_data_k, commit0_data, commit1_data, br_next_pc, correct_pc;
    logic [4:0]  commit0_reg, commit1_reg;
    logic [1:0]  commit_cnt;

    logic        s_dec_full, s_rd_ready_j, s_rd_ready_k, s_lsb_empty, s_br_en, s_br_taken, s_flush_out;
    logic [3:0]  s_dec_empty_id, s_commit0_id, s_lsb_head_id;
    logic [31:0] s_rd_data_j, s_rd_data_k, s_commit0_data, s_commit1_data, s_br_next_pc, s_correct_pc;
    logic [4:0]  s_commit0_reg, s_commit1_reg;
    logic [1:0]  s_commit_cnt;
    logic        s_dec_rdy;
    assign s_dec_rdy = dec_rdy & ~s_dec_full;

    int total = 0;
    int bad   = 0;

    always #5 clk_in = ~clk_in;

    reorder_buffer_mc dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
        .dec_full(dec_full), .dec_empty_id(dec_empty_id), .dec_rdy(dec_rdy),
        .dec_committable(dec_committable), .dec_res(dec_res), .dec_next_addr(dec_next_addr),
        .dec_jump_addr(dec_jump_addr), .dec_type(dec_type), .dec_dest(dec_dest),
        .dec_predict(dec_predict), .wb_valid(wb_valid), .wb_rob_id(wb_rob_id),
        .wb_data(wb_data), .wb_set_jump(wb_set_jump), .rd_id_j(rd_id_j), .rd_id_k(rd_id_k),
        .rd_ready_j(rd_ready_j), .rd_ready_k(rd_ready_k), .rd_data_j(rd_data_j),
        .rd_data_k(rd_data_k), .commit0_reg(commit0_reg), .commit1_reg(commit1_reg),
        .commit0_data(commit0_data), .commit1_data(commit1_data), .commit0_id(commit0_id),
        .commit_cnt(commit_cnt), .lsb_empty(lsb_empty), .lsb_head_id(lsb_head_id),
        .br_en(br_en), .br_next_pc(br_next_pc), .br_taken(br_taken),
        .flush_out(flush_out), .correct_pc(correct_pc)
    );

    reorder_buffer_mc #(.DUAL_COMMIT(0)) dut_single (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
        .dec_full(s_dec_full), .dec_empty_id(s_dec_empty_id), .dec_rdy(s_dec_rdy),
        .dec_committable(dec_committable), .dec_res(dec_res), .dec_next_addr(dec_next_addr),
        .dec_jump_addr(dec_jump_addr), .dec_type(dec_type), .dec_dest(dec_dest),
        .dec_predict(dec_predict), .wb_valid(wb_valid), .wb_rob_id(wb_rob_id),
        .wb_data(wb_data), .wb_set_jump(wb_set_jump), .rd_id_j(rd_id_j), .rd_id_k(rd_id_k),
        .rd_ready_j(s_rd_ready_j), .rd_ready_k(s_rd_ready_k), .rd_data_j(s_rd_data_j),
        .rd_data_k(s_rd_data_k), .commit0_reg(s_commit0_reg), .commit1_reg(s_commit1_reg),
        .commit0_data(s_commit0_data), .commit1_data(s_commit1_data), .commit0_id(s_commit0_id),
        .commit_cnt(s_commit_cnt), .lsb_empty(s_lsb_empty), .lsb_head_id(s_lsb_head_id),
        .br_en(s_br_en), .br_next_pc(s_br_next_pc), .br_taken(s_br_taken),
        .flush_out(s_flush_out), .correct_pc(s_correct_pc)
    );

    typedef struct {
        logic [3:0]  id;
        bit          comm;
        logic [31:0] res, nxt, jmp;
        logic [1:0]  typ;
        logic [4:0]  dest;
        bit          pred;
    } ent_t;

    ent_t        q[$];
    logic [3:0]  m_head, m_tail;
    bit          m_fo;
    logic [31:0] m_cpc;

    typedef struct {
        logic        dr, dc;
        logic [1:0]  dt;
        logic [4:0]  dd;
        logic [31:0] dres;
        logic        wv;
        logic [3:0]  wid;
        logic [31:0] wd;
        logic [1:0]  ecnt;
        logic [4:0]  er0, er1;
        logic [31:0] ed0, ed1;
        logic        eempty;
        logic [3:0]  eid;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_head = '0;
        m_tail = '0;
        m_fo   = 1'b0;
        m_cpc  = '0;
    endtask

    task automatic slots(output bit s0, output bit s1);
        int sz;
        sz = q.size();
        s0 = !m_fo && sz > 0 && q[0].comm;
        s1 = s0 && sz > 1 && q[1].comm && q[0].typ == 2'b01 && q[1].typ == 2'b01;
    endtask

    task automatic lookup(input logic [3:0] id, output bit valid, output bit rdy, output logic [31:0] data);
        valid = 1'b0;
        rdy   = 1'b0;
        data  = '0;
        foreach (q[n]) begin
            if (q[n].id == id) begin
                valid = 1'b1;
                rdy   = q[n].comm;
                data  = q[n].res;
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (wb_valid[i] && !wb_set_jump[i] && wb_rob_id[i*4 +: 4] == id) begin
                rdy  = 1'b1;
                data = wb_data[i*32 +: 32];
            end
        end
        if (dec_rdy && dec_committable && m_tail == id) begin
            valid = 1'b1;
            rdy   = 1'b1;
            data  = dec_res;
        end
    endtask

    task automatic model_check();
        bit s0, s1, v, r;
        logic [31:0] d;
        int sz;
        sz = q.size();
        slots(s0, s1);
        chk("dec_full", 32'(dec_full), 32'(sz == 16));
        chk("lsb_empty", 32'(lsb_empty), 32'(sz == 0));
        chk("dec_empty_id", 32'(dec_empty_id), 32'(m_tail));
        chk("lsb_head_id", 32'(lsb_head_id), 32'(m_head));
        chk("commit0_id", 32'(commit0_id), 32'(m_head));
        chk("commit_cnt", 32'(commit_cnt), 32'(s0) + 32'(s1));
        chk("commit0_reg", 32'(commit0_reg), (s0 && q[0].typ[0]) ? 32'(q[0].dest) : 0);
        chk("commit1_reg", 32'(commit1_reg), s1 ? 32'(q[1].dest) : 0);
        if (s0) chk("commit0_data", commit0_data, q[0].res);
        if (s1) chk("commit1_data", commit1_data, q[1].res);
        chk("br_en", 32'(br_en), 32'(s0 && q[0].typ[1]));
        if (s0 && q[0].typ[1]) begin
            chk("br_taken", 32'(br_taken), 32'(q[0].res[0]));
            chk("br_next_pc", br_next_pc, q[0].nxt);
        end
        chk("flush_out", 32'(flush_out), 32'(m_fo));
        chk("correct_pc", correct_pc, m_cpc);
        lookup(rd_id_j, v, r, d);
        if (v) begin
            chk("rd_ready_j", 32'(rd_ready_j), 32'(r));
            if (r) chk("rd_data_j", rd_data_j, d);
        end
        lookup(rd_id_k, v, r, d);
        if (v) begin
            chk("rd_ready_k", 32'(rd_ready_k), 32'(r));
            if (r) chk("rd_data_k", rd_data_k, d);
        end
        chk("single_commit_cap", 32'(s_commit_cnt == 2'd2), 0);
    endtask

    task automatic model_update();
        bit s0, s1, mis;
        ent_t e;
        if (!rst_in) begin
            model_clear();
        end else if (rdy_in) begin
            if (flush || m_fo) begin
                model_clear();
            end else begin
                slots(s0, s1);
                mis = s0 && q[0].typ[1] && (q[0].pred != q[0].res[0]);
                if (mis) m_cpc = q[0].pred ? q[0].nxt : q[0].jmp;
                m_fo = mis;
                if (s0) begin void'(q.pop_front()); m_head = m_head + 4'd1; end
                if (s1) begin void'(q.pop_front()); m_head = m_head + 4'd1; end
                if (dec_rdy) begin
                    e.id = m_tail; e.comm = dec_committable; e.res = dec_res;
                    e.nxt = dec_next_addr; e.jmp = dec_jump_addr; e.typ = dec_type;
                    e.dest = dec_dest; e.pred = dec_predict;
                    q.push_back(e);
                    m_tail = m_tail + 4'd1;
                end
                for (int i = 0; i < 2; i++) begin
                    if (wb_valid[i]) begin
                        foreach (q[n]) begin
                            if (q[n].id == wb_rob_id[i*4 +: 4]) begin
                                q[n].comm = 1'b1;
                                if (wb_set_jump[i]) q[n].jmp = wb_data[i*32 +: 32];
                                else q[n].res = wb_data[i*32 +: 32];
                            end
                        end
                    end
                end
            end
        end
    endtask

    task automatic idle();
        rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0;
        dec_rdy = 1'b0; dec_committable = 1'b0; dec_predict = 1'b0;
        dec_res = '0; dec_next_addr = '0; dec_jump_addr = '0; dec_type = '0; dec_dest = '0;
        wb_valid = '0; wb_set_jump = '0; wb_rob_id = '0; wb_data = '0;
        rd_id_j = '0; rd_id_k = '0;
    endtask

    task automatic pre();
        @(negedge clk_in);
    endtask

    task automatic post();
        model_check();
        @(posedge clk_in);
        model_update();
        #1;
    endtask

    task automatic step();
        pre();
        post();
    endtask

    task automatic do_reset();
        idle();
        rst_in = 1'b0;
        rdy_in = 1'b0;
        step();
        idle();
    endtask

    task automatic alloc(input logic comm, input logic [1:0] typ, input logic [4:0] dest,
                         input logic [31:0] res);
        idle();
        dec_rdy = 1'b1; dec_committable = comm; dec_type = typ; dec_dest = dest; dec_res = res;
        step();
    endtask

    initial begin
        tbl[0] = '{1, 0, 2'b01, 5, 32'h11, 0, 0, 0,     0, 0, 0, 0,     0,     1, 0};
        tbl[1] = '{1, 1, 2'b01, 6, 32'h22, 0, 0, 0,     0, 0, 0, 0,     0,     0, 1};
        tbl[2] = '{0, 0, 2'b00, 0, 0,      1, 0, 32'h11, 0, 0, 0, 0,    0,     0, 2};
        tbl[3] = '{0, 0, 2'b00, 0, 0,      0, 0, 0,     2, 5, 6, 32'h11, 32'h22, 0, 2};
        tbl[4] = '{1, 0, 2'b00, 0, 0,      0, 0, 0,     0, 0, 0, 0,     0,     1, 2};
        tbl[5] = '{1, 1, 2'b01, 7, 32'h77, 0, 0, 0,     0, 0, 0, 0,     0,     0, 3};
        tbl[6] = '{0, 0, 2'b00, 0, 0,      1, 2, 32'h5, 0, 0, 0, 0,     0,     0, 4};
        tbl[7] = '{0, 0, 2'b00, 0, 0,      0, 0, 0,     1, 0, 0, 32'h5, 0,     0, 4};
        tbl[8] = '{0, 0, 2'b00, 0, 0,      0, 0, 0,     1, 7, 0, 32'h77, 0,    0, 4};
        tbl[9] = '{0, 0, 2'b00, 0, 0,      0, 0, 0,     0, 0, 0, 0,     0,     1, 4};

        idle();
        rst_in = 1'b0;
        rdy_in = 1'b0;
        @(posedge clk_in);
        model_clear();
        #1;
        idle();

        pre();
        chk("rst_flush_out", 32'(flush_out), 0);
        chk("rst_lsb_empty", 32'(lsb_empty), 1);
        chk("rst_dec_full", 32'(dec_full), 0);
        chk("rst_commit_cnt", 32'(commit_cnt), 0);
        chk("rst_dec_empty_id", 32'(dec_empty_id), 0);
        post();

        foreach (tbl[r]) begin
            idle();
            dec_rdy = tbl[r].dr; dec_committable = tbl[r].dc; dec_type = tbl[r].dt;
            dec_dest = tbl[r].dd; dec_res = tbl[r].dres;
            wb_valid = {1'b0, tbl[r].wv}; wb_rob_id = {4'd0, tbl[r].wid}; wb_data = {32'd0, tbl[r].wd};
            pre();
            chk("tbl_commit_cnt", 32'(commit_cnt), 32'(tbl[r].ecnt));
            chk("tbl_commit0_reg", 32'(commit0_reg), 32'(tbl[r].er0));
            chk("tbl_commit1_reg", 32'(commit1_reg), 32'(tbl[r].er1));
            if (tbl[r].ecnt >= 1) chk("tbl_commit0_data", commit0_data, tbl[r].ed0);
            if (tbl[r].ecnt == 2) chk("tbl_commit1_data", commit1_data, tbl[r].ed1);
            chk("tbl_lsb_empty", 32'(lsb_empty), 32'(tbl[r].eempty));
            chk("tbl_dec_empty_id", 32'(dec_empty_id), 32'(tbl[r].eid));
            post();
        end

        do_reset();
        for (int i = 0; i < 16; i++) alloc(1'b0, 2'b01, 5'(i + 1), 32'(i * 3));
        idle();
        pre();
        chk("fill_dec_full", 32'(dec_full), 1);
        post();
        for (int c = 0; c < 9; c++) begin
            idle();
            if (c < 8) begin
                wb_valid = 2'b11;
                wb_rob_id = {4'(2 * c + 1), 4'(2 * c)};
                wb_data = {32'(200 + 2 * c + 1), 32'(200 + 2 * c)};
            end
            pre();
            if (c > 0) chk("drain_commit_cnt", 32'(commit_cnt), 2);
            post();
        end
        idle();
        pre();
        chk("drain_lsb_empty", 32'(lsb_empty), 1);
        chk("drain_tail_wrap", 32'(dec_empty_id), 0);
        chk("drain_head_wrap", 32'(lsb_head_id), 0);
        post();

        do_reset();
        dec_rdy = 1'b1; dec_type = 2'b10; dec_predict = 1'b1;
        dec_next_addr = 32'h104; dec_jump_addr = 32'h200;
        step();
        alloc(1'b1, 2'b01, 5'd9, 32'h99);
        idle();
        wb_valid = 2'b01; wb_rob_id = 8'h00; wb_data = 64'h0;
        step();
        idle();
        pre();
        chk("br_en", 32'(br_en), 1);
        chk("br_taken", 32'(br_taken), 0);
        chk("br_commit_cnt", 32'(commit_cnt), 1);
        chk("br_flush_early", 32'(flush_out), 0);
        post();
        pre();
        chk("br_flush_out", 32'(flush_out), 1);
        chk("br_correct_pc", correct_pc, 32'h104);
        chk("br_flush_commit", 32'(commit_cnt), 0);
        post();
        pre();
        chk("br_after_flush", 32'(flush_out), 0);
        chk("br_after_empty", 32'(lsb_empty), 1);
        post();

        do_reset();
        for (int i = 0; i < 4; i++) alloc(1'b0, 2'b01, 5'(i + 1), 32'(i));
        idle();
        wb_valid = 2'b11; wb_rob_id = 8'h33; wb_data = {32'hB, 32'hA};
        rd_id_j = 4'd3; rd_id_k = 4'd2;
        pre();
        chk("byp_ready_j", 32'(rd_ready_j), 1);
        chk("byp_data_j", rd_data_j, 32'hB);
        chk("byp_ready_k", 32'(rd_ready_k), 0);
        post();
        idle();
        step();

        for (int n = 0; n < 3000; n++) begin
            int k;
            idle();
            rdy_in = ($urandom % 10) != 0;
            flush  = ($urandom % 150) == 0;
            if (q.size() < 16 && ($urandom % 2) == 1) begin
                dec_rdy = 1'b1;
                dec_committable = ($urandom % 3) == 0;
                dec_type = 2'($urandom);
                dec_dest = 5'($urandom);
                dec_res = $urandom;
                dec_next_addr = $urandom;
                dec_jump_addr = $urandom;
                dec_predict = 1'($urandom);
            end
            for (int i = 0; i < 2; i++) begin
                if (q.size() > 0 && ($urandom % 3) == 0) begin
                    k = $urandom_range(q.size() - 1);
                    wb_valid[i] = 1'b1;
                    wb_rob_id[i*4 +: 4] = q[k].id;
                    wb_data[i*32 +: 32] = $urandom;
                    wb_set_jump[i] = q[k].typ[1] & 1'($urandom);
                end
            end
            if (q.size() > 0) begin
                rd_id_j = q[$urandom_range(q.size() - 1)].id;
                rd_id_k = q[$urandom_range(q.size() - 1)].id;
            end else begin
                rd_id_j = m_tail;
                rd_id_k = m_tail;
            end
            step();
        end

        idle();
        repeat (4) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
